// File: rtl/hsv_core_alu_arbiter.sv
// Round-robin arbiter sharing one ALU pipeline between two requesters, with an
// in-order tag FIFO that steers ALU results back to the originating requester.
package hsv_core_alu_arbiter_pkg;
  typedef struct packed {
    logic [3:0]  opcode;
    logic [4:0]  rd;
    logic [31:0] op_a;
    logic [31:0] op_b;
  } alu_data_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] result;
  } commit_data_t;
endpackage

module hsv_core_alu_arbiter
  import hsv_core_alu_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk_core,
  input  logic         rst_core,
  input  logic         flush_req,
  output logic         flush_ack,
  input  alu_data_t    in0_data,
  input  logic         in0_valid,
  output logic         in0_ready,
  input  alu_data_t    in1_data,
  input  logic         in1_valid,
  output logic         in1_ready,
  output alu_data_t    alu_data,
  output logic         alu_valid,
  input  logic         alu_ready,
  input  commit_data_t alu_commit,
  input  logic         alu_out_valid,
  output logic         alu_out_ready,
  output commit_data_t out0_data,
  output logic         out0_valid,
  input  logic         out0_ready,
  output commit_data_t out1_data,
  output logic         out1_valid,
  input  logic         out1_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("hsv_core_alu_arbiter: DEPTH must be a power of two >= 2");
  end

  typedef enum logic {
    S_RUN,
    S_FLUSH
  } state_e;

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [DEPTH-1:0] tag_q, tag_d;

  logic full, empty, flushing, active, eligible;
  logic grant, head, ret_ok, push, pop;

  // Full/empty come only from registered state, keeping alu_out_valid off the issue path.
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign flushing = flush_req || (state_q == S_FLUSH);
  assign active   = !rst_core && !flushing;
  assign head     = tag_q[rd_ptr_q];

  always_comb begin
    grant = ~last_grant_q;
    if (in0_valid && !in1_valid) begin
      grant = 1'b0;
    end else if (in1_valid && !in0_valid) begin
      grant = 1'b1;
    end
  end

  assign eligible  = active && !full && alu_ready;
  assign alu_valid = active && !full && (grant ? in1_valid : in0_valid);
  assign alu_data  = grant ? in1_data : in0_data;
  assign in0_ready = eligible && !grant;
  assign in1_ready = eligible && grant;
  assign push      = alu_valid && alu_ready;

  assign out0_data  = alu_commit;
  assign out1_data  = alu_commit;
  assign ret_ok     = active && !empty && alu_out_valid;
  assign out0_valid = ret_ok && !head;
  assign out1_valid = ret_ok && head;

  // While flushing, stale ALU results are accepted and dropped.
  always_comb begin
    alu_out_ready = 1'b0;
    if (!rst_core) begin
      if (flushing) begin
        alu_out_ready = 1'b1;
      end else if (!empty) begin
        alu_out_ready = head ? out1_ready : out0_ready;
      end
    end
  end

  assign pop       = ret_ok && alu_out_ready;
  assign flush_ack = (state_q == S_FLUSH);

  always_comb begin
    state_d      = flush_req ? S_FLUSH : S_RUN;
    last_grant_d = last_grant_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    tag_d        = tag_q;
    if (state_q == S_FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        tag_d[wr_ptr_q] = grant;
        wr_ptr_d        = wr_ptr_q + PW'(1);
        last_grant_d    = grant;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state_q      <= S_RUN;
      last_grant_q <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      tag_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      tag_q        <= tag_d;
    end
  end

  a_no_orphan_result : assert property (@(posedge clk_core) disable iff (rst_core)
    !(alu_out_valid && empty && active))
    else $error("hsv_core_alu_arbiter: ALU result returned with no op in flight");

endmodule

// File: tb/tb_hsv_core_alu_arbiter.sv
// Scoreboard bench: directed issue/return traffic with a simple in-order ALU
// stand-in; a negedge monitor pops expected issues/results on each handshake.
module tb_hsv_core_alu_arbiter;
  import hsv_core_alu_arbiter_pkg::*;

  typedef struct {
    logic      id;
    alu_data_t d;
  } iss_t;

  typedef struct {
    logic         id;
    commit_data_t c;
  } ret_t;

  logic         clk = 1'b0;
  logic         rst_core, flush_req, flush_ack;
  alu_data_t    in0_data, in1_data, alu_data;
  logic         in0_valid, in1_valid, in0_ready, in1_ready;
  logic         alu_valid, alu_ready;
  commit_data_t alu_commit, out0_data, out1_data;
  logic         alu_out_valid, alu_out_ready;
  logic         out0_valid, out0_ready, out1_valid, out1_ready;

  hsv_core_alu_arbiter #(.DEPTH(4)) dut (
    .clk_core     (clk),
    .rst_core     (rst_core),
    .flush_req    (flush_req),
    .flush_ack    (flush_ack),
    .in0_data     (in0_data),
    .in0_valid    (in0_valid),
    .in0_ready    (in0_ready),
    .in1_data     (in1_data),
    .in1_valid    (in1_valid),
    .in1_ready    (in1_ready),
    .alu_data     (alu_data),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_commit   (alu_commit),
    .alu_out_valid(alu_out_valid),
    .alu_out_ready(alu_out_ready),
    .out0_data    (out0_data),
    .out0_valid   (out0_valid),
    .out0_ready   (out0_ready),
    .out1_data    (out1_data),
    .out1_valid   (out1_valid),
    .out1_ready   (out1_ready)
  );

  always #5 clk = ~clk;

  int unsigned  n_checks = 0;
  int unsigned  n_pass   = 0;
  int unsigned  seq      = 0;
  iss_t         exp_iss[$];
  ret_t         exp_ret[$];
  commit_data_t pipe[$];

  // Controls applied to the DUT at the start of the next driven cycle.
  logic n_rst = 1'b1, n_flush = 1'b0, n_ret = 1'b0;
  logic n_or0 = 1'b1, n_or1 = 1'b1, n_ar = 1'b1;

  function automatic alu_data_t mk(input int unsigned s);
    alu_data_t d;
    d.opcode = 4'(s);
    d.rd     = 5'(s);
    d.op_a   = 32'(s * 7 + 3);
    d.op_b   = 32'(s * 13 + 11);
    return d;
  endfunction

  function automatic commit_data_t alu_fn(input alu_data_t d);
    commit_data_t c;
    c.rd     = d.rd;
    c.result = d.op_a + d.op_b;
    return c;
  endfunction

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  task automatic drive(input logic v0, input logic v1, input int expg);
    @(posedge clk);
    #1;
    seq++;
    rst_core      = n_rst;
    flush_req     = n_flush;
    alu_ready     = n_ar;
    out0_ready    = n_or0;
    out1_ready    = n_or1;
    in0_valid     = v0;
    in1_valid     = v1;
    in0_data      = mk(seq);
    in1_data      = mk(seq + 500);
    alu_out_valid = n_ret && (pipe.size() > 0);
    alu_commit    = (pipe.size() > 0) ? pipe[0] : '0;
    if (expg >= 0) exp_iss.push_back('{id: (expg == 1), d: (expg == 1) ? in1_data : in0_data});
  endtask

  iss_t         m_e;
  ret_t         m_r;
  commit_data_t m_tmp;

  always @(negedge clk) begin
    if (rst_core) begin
      pipe.delete();
    end else begin
      if (alu_valid && alu_ready) begin
        if (exp_iss.size() == 0) begin
          chk("unexpected_issue", 128'(alu_data), 128'(0));
        end else begin
          m_e = exp_iss.pop_front();
          chk("issue_id", 128'(in1_ready), 128'(m_e.id));
          chk("issue_data", 128'(alu_data), 128'(m_e.d));
          exp_ret.push_back('{id: m_e.id, c: alu_fn(m_e.d)});
        end
        pipe.push_back(alu_fn(alu_data));
      end
      if (alu_out_valid && alu_out_ready) begin
        if (pipe.size() > 0) m_tmp = pipe.pop_front();
        if (out0_valid || out1_valid) begin
          if (exp_ret.size() == 0) begin
            chk("unexpected_result", {out1_valid, out0_valid}, 128'(0));
          end else begin
            m_r = exp_ret.pop_front();
            chk("ret_port", 128'(out1_valid), 128'(m_r.id));
            chk("ret_data", out1_valid ? 128'(out1_data) : 128'(out0_data), 128'(m_r.c));
          end
        end
      end
    end
  end

  initial begin
    rst_core = 1'b1; flush_req = 1'b0; alu_ready = 1'b1;
    in0_valid = 1'b0; in1_valid = 1'b0; in0_data = '0; in1_data = '0;
    alu_commit = '0; alu_out_valid = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;

    // Reset state
    repeat (2) drive(1, 1, -1);
    @(negedge clk);
    chk("rst_in_ready", {in1_ready, in0_ready}, 128'(0));
    chk("rst_alu_valid", 128'(alu_valid), 128'(0));
    chk("rst_out_valid", {out1_valid, out0_valid}, 128'(0));
    chk("rst_alu_out_ready", 128'(alu_out_ready), 128'(0));
    chk("rst_flush_ack", 128'(flush_ack), 128'(0));

    // Tie, round-robin, immediate returns; one stalled cycle keeps last_grant
    n_rst = 1'b0; n_ret = 1'b1;
    for (int i = 0; i < 6; i++) drive(1, 1, i % 2);
    n_ar = 1'b0;
    drive(1, 1, -1);
    @(negedge clk);
    chk("stall_in_ready", {in1_ready, in0_ready}, 128'(0));
    n_ar = 1'b1;
    drive(1, 1, 0);
    repeat (3) drive(0, 0, -1);
    chk("tie_drained", 128'(exp_ret.size()), 128'(0));

    // Single requester 1: back-to-back grants
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 1);
      @(negedge clk);
      chk("single_in0_ready", 128'(in0_ready), 128'(0));
      chk("single_in1_ready", 128'(in1_ready), 128'(1));
    end
    repeat (3) drive(0, 0, -1);

    // Full: four issues then stall; one pop admits exactly one more
    n_ret = 1'b0; n_or0 = 1'b0; n_or1 = 1'b0;
    repeat (4) drive(1, 0, 0);
    repeat (2) begin
      drive(1, 0, -1);
      @(negedge clk);
      chk("full_alu_valid", 128'(alu_valid), 128'(0));
    end
    n_ret = 1'b1; n_or0 = 1'b1;
    drive(1, 0, -1);
    @(negedge clk);
    chk("full_pop_out0_valid", 128'(out0_valid), 128'(1));
    chk("full_pop_alu_valid", 128'(alu_valid), 128'(0));
    n_ret = 1'b0; n_or0 = 1'b0;
    drive(1, 0, 0);
    drive(1, 0, -1);
    @(negedge clk);
    chk("refull_alu_valid", 128'(alu_valid), 128'(0));
    n_ret = 1'b1; n_or0 = 1'b1; n_or1 = 1'b1;
    repeat (5) drive(0, 0, -1);

    // Per-requester backpressure: head tag 0 blocks a ready requester 1
    n_ret = 1'b0;
    drive(1, 0, 0);
    drive(0, 1, 1);
    n_ret = 1'b1; n_or0 = 1'b0; n_or1 = 1'b1;
    repeat (2) begin
      drive(0, 0, -1);
      @(negedge clk);
      chk("bp_alu_out_ready", 128'(alu_out_ready), 128'(0));
      chk("bp_out1_valid", 128'(out1_valid), 128'(0));
      chk("bp_out0_valid", 128'(out0_valid), 128'(1));
    end
    n_or0 = 1'b1;
    repeat (3) drive(0, 0, -1);
    chk("bp_drained", 128'(exp_ret.size()), 128'(0));

    // Flush with three ops in flight
    n_ret = 1'b0;
    drive(1, 1, 0);
    drive(1, 1, 1);
    drive(1, 1, 0);
    n_flush = 1'b1; n_ret = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) n_flush = 1'b0;
      drive(1, 1, -1);
      if (i == 0) exp_ret.delete();
      @(negedge clk);
      chk("flush_ack", 128'(flush_ack), 128'(i > 0));
      chk("flush_in_ready", {in1_ready, in0_ready}, 128'(0));
      chk("flush_alu_valid", 128'(alu_valid), 128'(0));
      chk("flush_out_valid", {out1_valid, out0_valid}, 128'(0));
      chk("flush_alu_out_ready", 128'(alu_out_ready), 128'(1));
    end
    drive(1, 1, 1);
    @(negedge clk);
    chk("flush_ack_fall", 128'(flush_ack), 128'(0));
    drive(1, 1, 0);
    repeat (3) drive(0, 0, -1);

    // Reset mid-operation with two ops in flight
    n_ret = 1'b0;
    drive(1, 1, 1);
    drive(1, 1, 0);
    n_rst = 1'b1; n_ret = 1'b1;
    drive(1, 1, -1);
    exp_ret.delete();
    @(negedge clk);
    chk("mid_rst_in_ready", {in1_ready, in0_ready}, 128'(0));
    chk("mid_rst_alu_valid", 128'(alu_valid), 128'(0));
    chk("mid_rst_out_valid", {out1_valid, out0_valid}, 128'(0));
    chk("mid_rst_alu_out_ready", 128'(alu_out_ready), 128'(0));
    n_rst = 1'b0;
    drive(1, 1, 0);
    drive(1, 1, 1);
    repeat (3) drive(0, 0, -1);

    @(negedge clk);
    chk("end_iss_empty", 128'(exp_iss.size()), 128'(0));
    chk("end_ret_empty", 128'(exp_ret.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
